// File: rtl/icache_lite.sv
// Direct-mapped read-only instruction cache for the prefetch port.
// A hit acks the cycle after acceptance; a miss refills the whole line in word beats.
module icache_lite #(
  parameter int unsigned LINES          = 64,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              kill_i,
  input  logic              flush_i,
  output logic              ack_o,
  output logic [31:0]       r_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned OFS    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX    = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX - OFS - 2;
  localparam int unsigned NWORDS = LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [OFS-1:0]    beat, beat_d;
  logic [LINES-1:0]  valid, valid_d;
  logic [TAG_W-1:0]  lat_tag, lat_tag_d;
  logic [IDX-1:0]    lat_idx, lat_idx_d;
  logic [OFS-1:0]    lat_ofs, lat_ofs_d;
  logic              kill_pend, kill_pend_d;
  logic              flush_pend, flush_pend_d;
  logic [31:0]       resp_word, resp_word_d;
  logic              ack_d;
  logic [31:0]       r_data_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              data_we;
  logic              tag_we;

  logic [31:0]       data_arr [NWORDS];
  logic [TAG_W-1:0]  tag_arr  [LINES];

  logic [TAG_W-1:0]  in_tag;
  logic [IDX-1:0]    in_idx;
  logic [OFS-1:0]    in_ofs;
  logic              unused_addr_lsbs;
  logic              accept;
  logic              hit;
  logic              last_beat;
  logic [31:0]       rd_word;

  assign in_tag           = addr_i[ADDR_W-1 -: TAG_W];
  assign in_idx           = addr_i[IDX+OFS+1 -: IDX];
  assign in_ofs           = addr_i[OFS+1 -: OFS];
  assign unused_addr_lsbs = ^addr_i[1:0];

  // A same-cycle flush forces the lookup to miss.
  assign accept    = req_i && !kill_i && !ack_o;
  assign hit       = valid[in_idx] && (tag_arr[in_idx] == in_tag) && !flush_i;
  assign rd_word   = data_arr[{in_idx, in_ofs}];
  assign last_beat = (beat == OFS'(WORDS_PER_LINE - 1));

  always_comb begin
    state_d      = state;
    beat_d       = beat;
    valid_d      = valid;
    lat_tag_d    = lat_tag;
    lat_idx_d    = lat_idx;
    lat_ofs_d    = lat_ofs;
    kill_pend_d  = kill_pend;
    flush_pend_d = flush_pend;
    resp_word_d  = resp_word;
    ack_d        = 1'b0;
    r_data_d     = r_data_o;
    mem_req_d    = mem_req_o;
    mem_addr_d   = mem_addr_o;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    if (flush_i) valid_d = '0;

    case (state)
      IDLE: begin
        if (accept) begin
          lat_tag_d = in_tag;
          lat_idx_d = in_idx;
          lat_ofs_d = in_ofs;
          if (hit) begin
            ack_d    = 1'b1;
            r_data_d = rd_word;
          end else begin
            state_d          = REFILL;
            beat_d           = '0;
            valid_d[in_idx]  = 1'b0;
            kill_pend_d      = 1'b0;
            flush_pend_d     = 1'b0;
            mem_req_d        = 1'b1;
            mem_addr_d       = {in_tag, in_idx, OFS'(0), 2'b00};
          end
        end
      end

      // Kill and flush seen during a refill are remembered until the last beat.
      REFILL: begin
        kill_pend_d  = kill_pend | kill_i;
        flush_pend_d = flush_pend | flush_i;
        if (mem_ack_i) begin
          data_we = 1'b1;
          if (beat == lat_ofs) resp_word_d = mem_rdata_i;
          if (last_beat) begin
            tag_we           = 1'b1;
            valid_d[lat_idx] = !(flush_pend || flush_i);
            mem_req_d        = 1'b0;
            beat_d           = '0;
            if (kill_pend || kill_i) begin
              state_d = IDLE;
            end else begin
              state_d  = RESP;
              ack_d    = 1'b1;
              r_data_d = (beat == lat_ofs) ? mem_rdata_i : resp_word;
            end
          end else begin
            beat_d     = beat + OFS'(1);
            mem_addr_d = {lat_tag, lat_idx, beat + OFS'(1), 2'b00};
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      valid      <= '0;
      lat_tag    <= '0;
      lat_idx    <= '0;
      lat_ofs    <= '0;
      kill_pend  <= 1'b0;
      flush_pend <= 1'b0;
      resp_word  <= '0;
      ack_o      <= 1'b0;
      r_data_o   <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      state      <= state_d;
      beat       <= beat_d;
      valid      <= valid_d;
      lat_tag    <= lat_tag_d;
      lat_idx    <= lat_idx_d;
      lat_ofs    <= lat_ofs_d;
      kill_pend  <= kill_pend_d;
      flush_pend <= flush_pend_d;
      resp_word  <= resp_word_d;
      ack_o      <= ack_d;
      r_data_o   <= r_data_d;
      mem_req_o  <= mem_req_d;
      mem_addr_o <= mem_addr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (data_we) data_arr[{lat_idx, beat}] <= mem_rdata_i;
    if (tag_we)  tag_arr[lat_idx]          <= lat_tag;
  end

endmodule

// File: tb/tb_icache_lite.sv
// Self-checking bench for icache_lite: directed scenarios then random fetches,
// checked against a line-presence model and a synthetic instruction memory.
module tb_icache_lite;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic [31:0] addr_i;
  logic        kill_i;
  logic        flush_i;
  logic        ack_o;
  logic [31:0] r_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: which 16-byte line address each index holds, and whether it is valid.
  bit          mvalid [64];
  logic [27:0] mline  [64];
  logic [31:0] exp_rdata;

  icache_lite dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .kill_i     (kill_i),
    .flush_i    (flush_i),
    .ack_o      (ack_o),
    .r_data_o   (r_data_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_0000: return 32'h0020_0093;
      32'h0000_0004: return 32'h0040_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0000_0013;
      default:       return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    model_flush();
    check("flush_no_ack", 32'(ack_o), 32'd0);
  endtask

  // Request with kill in the same cycle is never accepted.
  task automatic kill_hit(input logic [31:0] a);
    req_i  = 1'b1;
    addr_i = a;
    kill_i = 1'b1;
    step();
    req_i  = 1'b0;
    kill_i = 1'b0;
    check("kill_idle_ack", 32'(ack_o), 32'd0);
    check("kill_idle_mem", 32'(mem_req_o), 32'd0);
    step();
    check("kill_idle_hold", r_data_o, exp_rdata);
  endtask

  task automatic fetch(input logic [31:0] a, input int kill_beat, input int flush_beat,
                       input bit flush_req, input int max_wait);
    logic [31:0] line_base;
    logic [5:0]  idx;
    logic [31:0] exp_word;
    bit          exp_hit;
    bit          killed;
    bit          flushed;
    int          w;
    line_base = {a[31:4], 4'h0};
    idx       = a[9:4];
    exp_word  = mem_word(a);
    exp_hit   = !flush_req && mvalid[idx] && (mline[idx] == a[31:4]);
    killed    = 1'b0;
    flushed   = 1'b0;
    req_i     = 1'b1;
    addr_i    = a;
    flush_i   = flush_req;
    if (flush_req) model_flush();
    step();
    flush_i = 1'b0;
    if (exp_hit) begin
      check("hit_ack", 32'(ack_o), 32'd1);
      check("hit_data", r_data_o, exp_word);
      check("hit_no_mem", 32'(mem_req_o), 32'd0);
      exp_rdata = exp_word;
      req_i     = 1'b0;
    end else begin
      mvalid[idx] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        w = $urandom_range(max_wait, 0);
        for (int k = 0; k <= w; k++) begin
          check("refill_req", 32'(mem_req_o), 32'd1);
          check("refill_addr", mem_addr_o, line_base + 32'(4 * b));
          check("refill_no_ack", 32'(ack_o), 32'd0);
          if (k < w) step();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(line_base + 32'(4 * b));
        if (b == kill_beat) begin
          kill_i = 1'b1;
          req_i  = 1'b0;
          killed = 1'b1;
        end
        if (b == flush_beat) begin
          flush_i = 1'b1;
          flushed = 1'b1;
          model_flush();
        end
        step();
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        kill_i      = 1'b0;
        flush_i     = 1'b0;
      end
      if (!flushed) begin
        mvalid[idx] = 1'b1;
        mline[idx]  = a[31:4];
      end
      check("miss_ack", 32'(ack_o), 32'(!killed));
      if (!killed) begin
        check("miss_data", r_data_o, exp_word);
        exp_rdata = exp_word;
      end
      check("miss_mem_idle", 32'(mem_req_o), 32'd0);
      req_i = 1'b0;
    end
    step();
    check("no_double_ack", 32'(ack_o), 32'd0);
    check("rdata_hold", r_data_o, exp_rdata);
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    rst         = 1'b1;
    req_i       = 1'b0;
    addr_i      = '0;
    kill_i      = 1'b0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    exp_rdata   = '0;
    model_flush();
    step();
    step();
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_rdata", r_data_o, 32'd0);
    rst = 1'b0;
    step();

    // Cold miss, then hits on the same line (halfword PCs).
    fetch(32'h0000_0000, -1, -1, 1'b0, 0);
    fetch(32'h0000_0006, -1, -1, 1'b0, 2);
    fetch(32'h0000_000A, -1, -1, 1'b0, 2);
    // Conflicting tag evicts line 0.
    fetch(32'h0000_0400, -1, -1, 1'b0, 2);
    fetch(32'h0000_0000, -1, -1, 1'b0, 1);
    // Flush pulse, flush during refill, flush with request.
    flush_pulse();
    fetch(32'h0000_0000, -1, 2, 1'b0, 1);
    fetch(32'h0000_0000, -1, -1, 1'b0, 1);
    fetch(32'h0000_0004, -1, -1, 1'b1, 1);
    // Kill in beat 2, then the line is still usable.
    flush_pulse();
    fetch(32'h0000_0000, 2, -1, 1'b0, 1);
    fetch(32'h0000_0008, -1, -1, 1'b0, 0);
    kill_hit(32'h0000_0008);

    // Reset in the middle of a refill leaves the line invalid.
    req_i  = 1'b1;
    addr_i = 32'h0000_0810;
    step();
    check("rstmid_req", 32'(mem_req_o), 32'd1);
    rst   = 1'b1;
    req_i = 1'b0;
    step();
    rst = 1'b0;
    model_flush();
    exp_rdata = '0;
    check("rstmid_mem", 32'(mem_req_o), 32'd0);
    check("rstmid_ack", 32'(ack_o), 32'd0);
    fetch(32'h0000_0814, -1, -1, 1'b0, 1);

    for (int it = 0; it < 60; it++) begin
      ra = (32'($urandom_range(3, 0)) << 10) | (32'($urandom_range(3, 0)) << 4)
         | 32'($urandom_range(15, 0));
      r = $urandom_range(9, 0);
      case (r)
        0:       flush_pulse();
        1:       kill_hit(ra);
        2:       fetch(ra, $urandom_range(3, 0), -1, 1'b0, 2);
        3:       fetch(ra, -1, $urandom_range(3, 0), 1'b0, 2);
        4:       fetch(ra, -1, -1, 1'b1, 2);
        default: fetch(ra, -1, -1, 1'b0, 2);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
